// File: rtl/packet_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// packet_tx_arbiter_if
// Bundles the request-side AXI-Stream sources, the single transmit-side
// AXI-Stream master and the arbiter status lines into one interface.
//
// Parameters : NUM_REQ    - number of packet sources
//              DATA_WIDTH - AXIS data width on every port
// Signals    : req_en_i            per-source enable mask
//              s_tdata_i/s_tvalid_i/s_tlast_i/s_tready_o   source streams
//              m_tdata_o/m_tvalid_o/m_tlast_o/m_tready_i   transmitter stream
//              grant_o, busy_o, trunc_o                     status
// Modports   : master - the arbiter itself (drives m_*, s_tready_o, status)
//              slave  - the environment (sources, transmitter, control)
// -----------------------------------------------------------------------------
interface packet_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_en_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata_i;
  logic [NUM_REQ-1:0]            s_tvalid_i;
  logic [NUM_REQ-1:0]            s_tlast_i;
  logic [NUM_REQ-1:0]            s_tready_o;
  logic [DATA_WIDTH-1:0]         m_tdata_o;
  logic                          m_tvalid_o;
  logic                          m_tlast_o;
  logic                          m_tready_i;
  logic [NUM_REQ-1:0]            grant_o;
  logic                          busy_o;
  logic                          trunc_o;

  modport master (
    input  req_en_i, s_tdata_i, s_tvalid_i, s_tlast_i, m_tready_i,
    output s_tready_o, m_tdata_o, m_tvalid_o, m_tlast_o, grant_o, busy_o, trunc_o
  );

  modport slave (
    output req_en_i, s_tdata_i, s_tvalid_i, s_tlast_i, m_tready_i,
    input  s_tready_o, m_tdata_o, m_tvalid_o, m_tlast_o, grant_o, busy_o, trunc_o
  );
endinterface

// File: rtl/packet_tx_arbiter.sv
// -----------------------------------------------------------------------------
// packet_tx_arbiter
// Frame-atomic round-robin arbiter sharing one AXI-Stream transmit path among
// NUM_REQ packet sources. Whole frames are granted, an inter-frame gap of
// IFG_CYCLES idle cycles follows every frame, and (optionally) runaway frames
// longer than MAX_FRAME_BEATS are cut and the remainder drained.
//
// Ports : clk_i  - clock
//         rstn_i - asynchronous active-low reset
//         bus    - packet_tx_arbiter_if.master (sources, transmitter, status)
//
// Build option: define PKT_TX_ARB_TRUNC_EN to implement the beat counter,
// the DRAIN state and trunc_o. Without it, PASS ends only on source tlast
// and trunc_o is tied low.
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | no owner; pick next requester round-robin after the last winner
// PASS  | owner's stream forwarded combinationally to the transmitter
// DRAIN | frame was cut at the beat limit; swallow owner beats up to tlast
// GAP   | inter-frame gap, IFG_CYCLES cycles with everything held off
// -----------------------------------------------------------------------------
module packet_tx_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int IFG_CYCLES      = 12,
  parameter int MAX_FRAME_BEATS = 1518
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  packet_tx_arbiter_if.master bus
);

  localparam int         IDXW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] GAP_LOAD = (IFG_CYCLES > 0) ? 8'(IFG_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [IDXW-1:0]       r_gnt, w_gnt_nxt;
  logic [IDXW-1:0]       r_ptr, w_ptr_nxt;
  logic [IDXW-1:0]       w_win_idx;
  logic [7:0]            r_gap_cnt, w_gap_nxt;
  logic [NUM_REQ-1:0]    w_req;
  int                    w_cand;
  logic [DATA_WIDTH-1:0] w_src_data;
  logic                  w_src_valid;
  logic                  w_src_last;
  logic                  w_frame_end;
  logic [DATA_WIDTH-1:0] w_m_tdata;
  logic                  w_m_tvalid;
  logic                  w_m_tlast;
  logic [NUM_REQ-1:0]    w_s_tready;
  logic [NUM_REQ-1:0]    w_grant;

`ifdef PKT_TX_ARB_TRUNC_EN
  localparam int              BEATW      = $clog2(MAX_FRAME_BEATS);
  localparam logic [BEATW-1:0] BEAT_LIMIT = BEATW'(MAX_FRAME_BEATS - 1);

  logic [BEATW-1:0] r_beat_cnt, w_beat_nxt;
  logic             r_trunc, w_trunc_nxt;
  logic             w_at_limit;
`endif

  assign w_req = bus.s_tvalid_i & bus.req_en_i;

  // Round-robin pick: scan from the farthest candidate back to ptr+1 so the
  // nearest requester after the last winner is the one left standing.
  always_comb begin
    w_win_idx = r_ptr;
    w_cand    = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_cand = (int'(r_ptr) + i) % NUM_REQ;
      if (w_req[w_cand[IDXW-1:0]]) w_win_idx = w_cand[IDXW-1:0];
    end
  end

  assign w_src_data  = bus.s_tdata_i[r_gnt*DATA_WIDTH +: DATA_WIDTH];
  assign w_src_valid = bus.s_tvalid_i[r_gnt];
  assign w_src_last  = bus.s_tlast_i[r_gnt];

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_gap_nxt   = r_gap_cnt;
    w_m_tdata   = '0;
    w_m_tvalid  = 1'b0;
    w_m_tlast   = 1'b0;
    w_s_tready  = '0;
    w_grant     = '0;
    w_frame_end = 1'b0;
`ifdef PKT_TX_ARB_TRUNC_EN
    w_beat_nxt  = r_beat_cnt;
    w_trunc_nxt = 1'b0;
    w_at_limit  = (r_beat_cnt == BEAT_LIMIT);
`endif

    case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_gnt_nxt   = w_win_idx;
          w_state_nxt = ST_PASS;
        end
      end

      ST_PASS: begin
        w_grant[r_gnt]    = 1'b1;
        w_m_tdata         = w_src_data;
        w_m_tvalid        = w_src_valid;
        w_m_tlast         = w_src_last;
        w_s_tready[r_gnt] = bus.m_tready_i;
`ifdef PKT_TX_ARB_TRUNC_EN
        // The limit beat always carries tlast so the transmitter sees a
        // properly closed frame even when the source keeps going.
        if (w_at_limit) w_m_tlast = 1'b1;
        if (w_src_valid && bus.m_tready_i) begin
          if (w_src_last) begin
            w_frame_end = 1'b1;
          end else if (w_at_limit) begin
            w_state_nxt = ST_DRAIN;
            w_trunc_nxt = 1'b1;
            w_beat_nxt  = '0;
          end else begin
            w_beat_nxt = r_beat_cnt + 1'b1;
          end
        end
`else
        if (w_src_valid && bus.m_tready_i && w_src_last) w_frame_end = 1'b1;
`endif
      end

`ifdef PKT_TX_ARB_TRUNC_EN
      ST_DRAIN: begin
        w_grant[r_gnt]    = 1'b1;
        w_s_tready[r_gnt] = 1'b1;
        if (w_src_valid && w_src_last) w_frame_end = 1'b1;
      end
`endif

      ST_GAP: begin
        if (r_gap_cnt == 8'd0) w_state_nxt = ST_IDLE;
        else                   w_gap_nxt   = r_gap_cnt - 1'b1;
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    // Common frame-close path for normal tlast and end-of-drain.
    if (w_frame_end) begin
      w_ptr_nxt = r_gnt;
`ifdef PKT_TX_ARB_TRUNC_EN
      w_beat_nxt = '0;
`endif
      if (IFG_CYCLES == 0) begin
        w_state_nxt = ST_IDLE;
      end else begin
        w_state_nxt = ST_GAP;
        w_gap_nxt   = GAP_LOAD;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_ptr     <= IDXW'(NUM_REQ - 1);
      r_gap_cnt <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gap_cnt <= w_gap_nxt;
    end
  end

`ifdef PKT_TX_ARB_TRUNC_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_beat_cnt <= '0;
      r_trunc    <= 1'b0;
    end else begin
      r_beat_cnt <= w_beat_nxt;
      r_trunc    <= w_trunc_nxt;
    end
  end

  assign bus.trunc_o = r_trunc;
`else
  assign bus.trunc_o = 1'b0;
`endif

  assign bus.m_tdata_o  = w_m_tdata;
  assign bus.m_tvalid_o = w_m_tvalid;
  assign bus.m_tlast_o  = w_m_tlast;
  assign bus.s_tready_o = w_s_tready;
  assign bus.grant_o    = w_grant;
  assign bus.busy_o     = (r_state != ST_IDLE);

endmodule
